// File: rtl/wb_arbiter_if.sv
// Bundle of the two writeback requesters and the register-file write port.
// The arbiter takes the slave side; requesters/bench drive the master side.
interface wb_arbiter_if;
  logic        A_VALID;
  logic        A_READY;
  logic [4:0]  A_ADDR;
  logic [31:0] A_DATA;
  logic        B_VALID;
  logic        B_READY;
  logic [4:0]  B_ADDR;
  logic [31:0] B_DATA;
  logic        WE;
  logic [4:0]  WADDR;
  logic [31:0] WDATA;
  logic        LAST_SRC;

  modport master (
    output A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
    input  A_READY, B_READY, WE, WADDR, WDATA, LAST_SRC
  );

  modport slave (
    input  A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
    output A_READY, B_READY, WE, WADDR, WDATA, LAST_SRC
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-source register-file write arbiter: A (ALU) has priority, but B (load)
// is guaranteed a grant after at most MAXRUN consecutive A grants.
module wb_arbiter #(
  parameter int MAXRUN  = 4,
  parameter int DROP_R0 = 1
) (
  input  logic         CLK,
  input  logic         RST,
  wb_arbiter_if.slave  bus
);

  localparam logic [3:0] MAXRUN_C = 4'(MAXRUN);

  logic [3:0]  run_q, run_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        last_src_q, last_src_d;

  logic        a_grant, b_grant, xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // Grants are combinational so a single-cycle request can transfer immediately.
  always_comb begin
    a_grant = !RST && bus.A_VALID && (!bus.B_VALID || (run_q < MAXRUN_C));
    b_grant = !RST && bus.B_VALID && !(bus.A_VALID && (run_q < MAXRUN_C));
  end

  assign bus.A_READY = a_grant;
  assign bus.B_READY = b_grant;

  always_comb begin
    xfer     = a_grant || b_grant;
    sel_addr = b_grant ? bus.B_ADDR : bus.A_ADDR;
    sel_data = b_grant ? bus.B_DATA : bus.A_DATA;

    run_d = run_q;
    if (b_grant || !bus.B_VALID) begin
      run_d = '0;
    end else if (a_grant) begin
      run_d = (run_q >= MAXRUN_C) ? MAXRUN_C : run_q + 4'd1;
    end

    // r0 is hardwired zero in the register file, so its writes can be squashed.
    we_d       = xfer && !((DROP_R0 != 0) && (sel_addr == 5'd0));
    waddr_d    = xfer ? sel_addr : waddr_q;
    wdata_d    = xfer ? sel_data : wdata_q;
    last_src_d = xfer ? b_grant  : last_src_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      last_src_q <= 1'b0;
    end else begin
      run_q      <= run_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      last_src_q <= last_src_d;
    end
  end

  assign bus.WE       = we_q;
  assign bus.WADDR    = waddr_q;
  assign bus.WDATA    = wdata_q;
  assign bus.LAST_SRC = last_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a rule-level reference model of
// the arbitration, output register stage and register-file contents.
module tb_wb_arbiter;

  localparam int MAXRUN = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  wb_arbiter_if bus ();
  wb_arbiter_if bus2 ();

  wb_arbiter #(.MAXRUN(MAXRUN), .DROP_R0(1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Second instance sees identical requests but keeps r0 writes.
  assign bus2.A_VALID = bus.A_VALID;
  assign bus2.A_ADDR  = bus.A_ADDR;
  assign bus2.A_DATA  = bus.A_DATA;
  assign bus2.B_VALID = bus.B_VALID;
  assign bus2.B_ADDR  = bus.B_ADDR;
  assign bus2.B_DATA  = bus.B_DATA;

  wb_arbiter #(.MAXRUN(MAXRUN), .DROP_R0(0)) dut_keep_r0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus2)
  );

  // Register file built from what the DUT actually writes.
  logic [31:0] dut_rf [32];
  always @(posedge CLK) begin
    if (bus.WE) dut_rf[bus.WADDR] <= bus.WDATA;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          waited;
  logic        exp_we;
  logic        exp_last;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [31:0] model_rf [32];
  bit          model_wr [32];

  task automatic model_reset();
    waited    = 0;
    exp_we    = 1'b0;
    exp_last  = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  // One clock of stimulus: checks the registered outputs left by the previous
  // cycle, applies new requests, checks the grants and advances the model.
  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       output logic ra, output logic rb);
    logic ga, gb;
    @(negedge CLK);
    checks++;
    if (bus.WE !== exp_we) begin
      errors++; $display("FAIL we: got %b want %b at %0t", bus.WE, exp_we, $time);
    end
    checks++;
    if (bus.WADDR !== exp_waddr) begin
      errors++; $display("FAIL waddr: got %0d want %0d at %0t", bus.WADDR, exp_waddr, $time);
    end
    checks++;
    if (bus.WDATA !== exp_wdata) begin
      errors++; $display("FAIL wdata: got %h want %h at %0t", bus.WDATA, exp_wdata, $time);
    end
    checks++;
    if (bus.LAST_SRC !== exp_last) begin
      errors++; $display("FAIL last_src: got %b want %b at %0t", bus.LAST_SRC, exp_last, $time);
    end
    if (exp_we) begin
      model_rf[exp_waddr] = exp_wdata;
      model_wr[exp_waddr] = 1'b1;
    end

    bus.A_VALID = av; bus.A_ADDR = aa; bus.A_DATA = ad;
    bus.B_VALID = bv; bus.B_ADDR = ba; bus.B_DATA = bd;
    #2;
    ga = av && (!bv || waited < MAXRUN);
    gb = bv && !ga;
    ra = bus.A_READY;
    rb = bus.B_READY;
    checks++;
    if (ra !== ga) begin
      errors++; $display("FAIL a_ready: got %b want %b at %0t", ra, ga, $time);
    end
    checks++;
    if (rb !== gb) begin
      errors++; $display("FAIL b_ready: got %b want %b at %0t", rb, gb, $time);
    end

    if (ga || gb) begin
      exp_last  = gb;
      exp_waddr = gb ? ba : aa;
      exp_wdata = gb ? bd : ad;
      exp_we    = (exp_waddr != 5'd0);
      $display("txn t=%0t src=%s addr=%0d data=%h", $time, gb ? "B" : "A", exp_waddr, exp_wdata);
    end else begin
      exp_we = 1'b0;
    end
    if (gb || !bv) waited = 0;
    else if (ga && waited < MAXRUN) waited++;
  endtask

  task automatic idle(int n);
    logic ra, rb;
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
  endtask

  task automatic test_reset();
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd3; bus.A_DATA = 32'h1;
    bus.B_VALID = 1'b1; bus.B_ADDR = 5'd4; bus.B_DATA = 32'h2;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (bus.A_READY !== 1'b0 || bus.B_READY !== 1'b0) begin
        errors++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", bus.A_READY, bus.B_READY);
      end
      checks++;
      if (bus.WE !== 1'b0 || bus.WADDR !== 5'd0 || bus.WDATA !== 32'd0 || bus.LAST_SRC !== 1'b0) begin
        errors++; $display("FAIL reset_outputs: got we=%b waddr=%0d wdata=%h last=%b want all 0",
                           bus.WE, bus.WADDR, bus.WDATA, bus.LAST_SRC);
      end
    end
    @(negedge CLK);
    bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_single_a();
    logic ra, rb;
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ra, rb);
    checks++;
    if (ra !== 1'b1) begin
      errors++; $display("FAIL single_a_ready: got %b want 1", ra);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
    checks++;
    if (bus.WE !== 1'b1 || bus.WADDR !== 5'd5 || bus.WDATA !== 32'hDEADBEEF || bus.LAST_SRC !== 1'b0) begin
      errors++; $display("FAIL single_a_write: got we=%b waddr=%0d wdata=%h last=%b want 1 5 deadbeef 0",
                         bus.WE, bus.WADDR, bus.WDATA, bus.LAST_SRC);
    end
    idle(1);
  endtask

  task automatic test_starvation();
    logic ra, rb;
    logic [31:0] ad, bd;
    ad = $urandom; bd = $urandom;
    idle(1);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 5'd10, ad, 1'b1, 5'd11, bd, ra, rb);
      checks++;
      if (rb !== ((i % 5) == 4)) begin
        errors++; $display("FAIL starvation_pattern: cycle %0d got b_ready=%b want %b", i, rb, (i % 5) == 4);
      end
      if (ra) ad = $urandom;
      if (rb) bd = $urandom;
    end
    idle(2);
  endtask

  task automatic test_collision();
    logic ra, rb;
    cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, ra, rb);
    checks++;
    if (ra !== 1'b1 || rb !== 1'b0) begin
      errors++; $display("FAIL collision_first: got a=%b b=%b want 1 0", ra, rb);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2, ra, rb);
    checks++;
    if (rb !== 1'b1 || bus.WDATA !== 32'd1) begin
      errors++; $display("FAIL collision_second: got b=%b wdata=%h want 1 00000001", rb, bus.WDATA);
    end
    idle(2);
    checks++;
    if (dut_rf[7] !== 32'd2) begin
      errors++; $display("FAIL collision_r7: got %h want 00000002", dut_rf[7]);
    end
  endtask

  task automatic test_drop_r0();
    logic ra, rb;
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, ra, rb);
    checks++;
    if (rb !== 1'b1) begin
      errors++; $display("FAIL drop_b_ready: got %b want 1", rb);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
    checks++;
    if (bus.WE !== 1'b0 || bus.LAST_SRC !== 1'b1) begin
      errors++; $display("FAIL drop_r0_on: got we=%b last=%b want 0 1", bus.WE, bus.LAST_SRC);
    end
    checks++;
    if (bus2.WE !== 1'b1 || bus2.WADDR !== 5'd0 || bus2.WDATA !== 32'h12345678) begin
      errors++; $display("FAIL drop_r0_off: got we=%b waddr=%0d wdata=%h want 1 0 12345678",
                         bus2.WE, bus2.WADDR, bus2.WDATA);
    end
    idle(1);
  endtask

  task automatic test_async_reset();
    logic ra, rb;
    idle(1);
    cycle(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd12, 32'h5A5A5A5A, ra, rb);
    cycle(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd12, 32'h5A5A5A5A, ra, rb);
    @(posedge CLK); #2;
    checks++;
    if (bus.WE !== 1'b1) begin
      errors++; $display("FAIL pre_reset_we: got %b want 1", bus.WE);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (bus.WE !== 1'b0 || bus.WADDR !== 5'd0 || bus.WDATA !== 32'd0 || bus.LAST_SRC !== 1'b0) begin
      errors++; $display("FAIL async_reset_outputs: got we=%b waddr=%0d wdata=%h last=%b want all 0",
                         bus.WE, bus.WADDR, bus.WDATA, bus.LAST_SRC);
    end
    checks++;
    if (bus.A_READY !== 1'b0 || bus.B_READY !== 1'b0) begin
      errors++; $display("FAIL async_reset_ready: got a=%b b=%b want 0 0", bus.A_READY, bus.B_READY);
    end
    RST = 1'b0;
    model_reset();
    cycle(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd12, 32'h5A5A5A5A, ra, rb);
    checks++;
    if (ra !== 1'b1 || rb !== 1'b0) begin
      errors++; $display("FAIL post_reset_grant: got a=%b b=%b want 1 0", ra, rb);
    end
    idle(2);
  endtask

  task automatic test_random();
    logic ra, rb;
    logic pa, pb;
    logic [4:0] aa, ba;
    logic [31:0] ad, bd;
    pa = 1'b0; pb = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa && ($urandom_range(0, 3) != 0)) begin
        pa = 1'b1; aa = 5'($urandom_range(0, 31)); ad = $urandom;
      end
      if (!pb && ($urandom_range(0, 2) == 0)) begin
        pb = 1'b1; ba = 5'($urandom_range(0, 31)); bd = $urandom;
      end
      cycle(pa, aa, ad, pb, ba, bd, ra, rb);
      if (ra) pa = 1'b0;
      if (rb) pb = 1'b0;
    end
    idle(2);
    for (int r = 0; r < 32; r++) begin
      if (model_wr[r]) begin
        checks++;
        if (dut_rf[r] !== model_rf[r]) begin
          errors++; $display("FAIL regfile r%0d: got %h want %h", r, dut_rf[r], model_rf[r]);
        end
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      model_rf[r] = '0;
      model_wr[r] = 1'b0;
    end
    model_reset();
    bus.A_VALID = 1'b0; bus.A_ADDR = '0; bus.A_DATA = '0;
    bus.B_VALID = 1'b0; bus.B_ADDR = '0; bus.B_DATA = '0;

    test_reset();
    test_single_a();
    test_starvation();
    test_collision();
    test_drop_r0();
    test_async_reset();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
